// File: rtl/score_digit_driver_pkg.sv
// Shared types and constants for the score readout: glyph geometry, FSM states,
// default saturation limit and a counter-width helper.
package score_pkg;

  localparam int GLYPH_W       = 8;
  localparam int GLYPH_H       = 16;
  localparam int DEF_MAX_VALUE = 9999;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/score_digit_driver_if.sv
// Score input, raster position and glyph-request outputs of the score readout;
// master drives score/raster, slave is the digit driver.
interface score_digit_driver_if #(
  parameter int VALUE_W = 14
);
  import score_pkg::*;

  logic [VALUE_W-1:0] value;
  logic               frame_start;
  logic [9:0]         drawX;
  logic [9:0]         drawY;
  logic               busy;
  logic [3:0]         number;
  logic [9:0]         relativeXF;
  logic [9:0]         relativeYF;
  logic               digit_on;

  modport master (
    output value, frame_start, drawX, drawY,
    input  busy, number, relativeXF, relativeYF, digit_on
  );

  modport slave (
    input  value, frame_start, drawX, drawY,
    output busy, number, relativeXF, relativeYF, digit_on
  );

endinterface

// File: rtl/score_digit_driver_bin2bcd.sv
// Serial double-dabble binary-to-BCD converter: BIN_W+1 busy cycles per start,
// one-cycle done pulse; start is ignored while busy (no queuing).
module bin2bcd_serial
  import score_pkg::*;
#(
  parameter int BIN_W      = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int SR_W  = 4*NUM_DIGITS + BIN_W;
  localparam int CNT_W = cnt_w(BIN_W);

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [SR_W-1:0]   adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    adj     = sr_q;
    // Add-3 correction is applied to every BCD nibble before the shift.
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (adj[BIN_W+4*d +: 4] >= 4'd5)
        adj[BIN_W+4*d +: 4] = adj[BIN_W+4*d +: 4] + 4'd3;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {{(4*NUM_DIGITS){1'b0}}, bin};
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        sr_d  = {adj[SR_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W-1))
          state_d = COMMIT;
      end
      COMMIT: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign bcd  = sr_q[SR_W-1 -: 4*NUM_DIGITS];

endmodule

// File: rtl/score_digit_driver.sv
// Score readout glyph requester: saturates and converts the score each frame, commits
// digits atomically, maps box pixels to {digit, rel x, rel y} with 1-cycle latency.
module score_digit_driver
  import score_pkg::*;
#(
  parameter int VALUE_W    = 14,
  parameter int NUM_DIGITS = 4,
  parameter int ORIGIN_X   = 560,
  parameter int ORIGIN_Y   = 16,
  parameter int MAX_VALUE  = DEF_MAX_VALUE
) (
  input  logic                 vga_clk,
  input  logic                 reset_n,
  score_digit_driver_if.slave  bus
);

  logic [VALUE_W-1:0]      sat;
  logic                    conv_done;
  logic [4*NUM_DIGITS-1:0] conv_bcd;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [3:0]              dig   [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank;
  logic                    lead_zero;

  logic                    in_box;
  logic [9:0]              rel_x, rel_y;
  logic [6:0]              idx;
  logic [3:0]              number_q, number_d;
  logic [9:0]              rel_x_q, rel_x_d, rel_y_q, rel_y_d;
  logic                    on_q, on_d;

  assign sat = (bus.value > VALUE_W'(MAX_VALUE)) ? VALUE_W'(MAX_VALUE) : bus.value;

  bin2bcd_serial #(
    .BIN_W      (VALUE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .start (bus.frame_start),
    .bin   (sat),
    .busy  (bus.busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign digits_d = conv_done ? conv_bcd : digits_q;

  always_comb begin
    lead_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig[i]    = digits_q[4*(NUM_DIGITS-1-i) +: 4];
      lead_zero = lead_zero && (dig[i] == 4'd0);
      blank[i]  = lead_zero && (i < NUM_DIGITS-1);
    end
  end

  assign in_box = (bus.drawX >= 10'(ORIGIN_X)) &&
                  (bus.drawX <  10'(ORIGIN_X + GLYPH_W*NUM_DIGITS)) &&
                  (bus.drawY >= 10'(ORIGIN_Y)) &&
                  (bus.drawY <  10'(ORIGIN_Y + GLYPH_H));
  assign rel_x  = bus.drawX - 10'(ORIGIN_X);
  assign rel_y  = bus.drawY - 10'(ORIGIN_Y);
  assign idx    = rel_x[9:3];

  always_comb begin
    number_d = 4'd0;
    rel_x_d  = 10'd0;
    rel_y_d  = 10'd0;
    on_d     = 1'b0;
    if (in_box) begin
      rel_x_d = rel_x;
      rel_y_d = rel_y;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx == 7'(i)) begin
          number_d = dig[i];
          on_d     = !blank[i];
        end
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      digits_q <= '0;
      number_q <= '0;
      rel_x_q  <= '0;
      rel_y_q  <= '0;
      on_q     <= 1'b0;
    end else begin
      digits_q <= digits_d;
      number_q <= number_d;
      rel_x_q  <= rel_x_d;
      rel_y_q  <= rel_y_d;
      on_q     <= on_d;
    end
  end

  assign bus.number     = number_q;
  assign bus.relativeXF = rel_x_q;
  assign bus.relativeYF = rel_y_q;
  assign bus.digit_on   = on_q;

endmodule

// File: tb/tb_score_digit_driver.sv
// Randomized self-checking bench for score_digit_driver against an arithmetic
// model of the displayed score and the score-box pixel map.
module tb_score_digit_driver;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   model_val;

  score_digit_driver_if #(.VALUE_W(14)) bus ();

  score_digit_driver #(
    .VALUE_W    (14),
    .NUM_DIGITS (4),
    .ORIGIN_X   (560),
    .ORIGIN_Y   (16),
    .MAX_VALUE  (9999)
  ) dut (
    .vga_clk (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  // Drive a raster position, then check the registered response one cycle later.
  task automatic pixel(input int x, input int y);
    int in_box, pos, e_num, e_rx, e_ry, e_on;
    @(negedge clk);
    bus.drawX = 10'(x);
    bus.drawY = 10'(y);
    @(posedge clk);
    #1;
    in_box = (x >= 560 && x < 592 && y >= 16 && y < 32);
    e_num = 0; e_rx = 0; e_ry = 0; e_on = 0;
    if (in_box) begin
      pos   = 3 - (x - 560) / 8;
      e_rx  = x - 560;
      e_ry  = y - 16;
      e_num = (model_val / pow10(pos)) % 10;
      e_on  = (pos == 0 || model_val >= pow10(pos)) ? 1 : 0;
    end
    check($sformatf("number@%0d,%0d", x, y), bus.number, e_num);
    check($sformatf("relX@%0d,%0d", x, y), bus.relativeXF, e_rx);
    check($sformatf("relY@%0d,%0d", x, y), bus.relativeYF, e_ry);
    check($sformatf("on@%0d,%0d", x, y), bus.digit_on, e_on);
  endtask

  task automatic scan();
    for (int i = 0; i < 4; i++)
      pixel(560 + 8*i + $urandom_range(0, 7), 16 + $urandom_range(0, 15));
    pixel(560, 16);
    pixel(587, 20);
    pixel(591, 31);
    pixel(592, 20);
    pixel(560, 32);
    pixel(559, 20);
    pixel(584, 15);
    for (int i = 0; i < 4; i++)
      pixel($urandom_range(540, 610), $urandom_range(0, 40));
  endtask

  // Pulse frame_start with value v; optionally retrigger with 42 mid-conversion.
  task automatic convert(input int v, input bit retrigger);
    int n;
    @(negedge clk);
    bus.value       = 14'(v);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      bus.frame_start = (retrigger && n == 5);
      if (retrigger && n == 5) bus.value = 14'd42;
      @(negedge clk);
    end
    bus.frame_start = 1'b0;
    check($sformatf("busy_len v=%0d", v), n, 15);
    model_val = (v > 9999) ? 9999 : v;
    @(negedge clk);
    check("busy_idle", bus.busy, 0);
  endtask

  initial begin
    int fixed_vals[6] = '{1234, 7, 1005, 12000, 9999, 0};
    checks = 0;
    errors = 0;
    model_val = 0;
    rst_n = 1'b0;
    bus.value = '0;
    bus.frame_start = 1'b0;
    bus.drawX = '0;
    bus.drawY = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_number", bus.number, 0);
    check("rst_relX", bus.relativeXF, 0);
    check("rst_relY", bus.relativeYF, 0);
    check("rst_on", bus.digit_on, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int x = 560; x < 592; x += 3) pixel(x, 16 + (x % 16));

    for (int i = 0; i < 6; i++) begin
      convert(fixed_vals[i], 1'b0);
      scan();
    end

    convert(1234, 1'b1);
    scan();

    for (int i = 0; i < 12; i++) begin
      convert($urandom_range(0, 16383), 1'b0);
      scan();
    end

    // Asynchronous reset in the middle of a conversion.
    convert(8765, 1'b0);
    @(negedge clk);
    bus.drawX = 10'd587;
    bus.drawY = 10'd20;
    bus.value = 14'd4321;
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_mid_conv", bus.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_busy", bus.busy, 0);
    check("async_number", bus.number, 0);
    check("async_on", bus.digit_on, 0);
    check("async_relX", bus.relativeXF, 0);
    model_val = 0;
    @(negedge clk);
    rst_n = 1'b1;
    scan();
    check("post_rst_busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
